// File: rtl/noc_cpu_port.sv
// NoC endpoint for one CPU: ingress FIFO (CPU -> network, tagged with cpu_index) and egress FIFO
// (network -> CPU), transfer counters with sticky done flags. NOC_CPU_PORT_CHECKSUM_EN adds XOR checksums.
`timescale 1ns/1ps

module noc_cpu_port_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Callers only push when not full and only pop when not empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
endmodule

module noc_cpu_port #(
  parameter int DEPTH          = 4,
  parameter int TRANSACTION_NB = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_index,
  input  logic        data_cpu_to_noc_vld,
  input  logic [63:0] data_cpu_to_noc,
  output logic        data_cpu_to_noc_rdy,
  output logic        data_noc_to_cpu_vld,
  output logic [63:0] data_noc_to_cpu,
  input  logic        data_noc_to_cpu_rdy,
  output logic        net_out_vld,
  output logic [63:0] net_out_data,
  output logic [31:0] net_out_src,
  input  logic        net_out_rdy,
  input  logic        net_in_vld,
  input  logic [63:0] net_in_data,
  output logic        net_in_rdy,
  output logic [31:0] tx_count,
  output logic [31:0] rx_count,
  output logic        tx_done,
  output logic        rx_done
`ifdef NOC_CPU_PORT_CHECKSUM_EN
  ,
  output logic [63:0] tx_checksum,
  output logic [63:0] rx_checksum
`endif
);
  logic        up_q, up_d;
  logic        ing_full, ing_empty, eg_full, eg_empty;
  logic [95:0] ing_head;
  logic        tx_fire, rx_fire, ing_pop, eg_push;
  logic [31:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic        tx_done_q, tx_done_d, rx_done_q, rx_done_d;

  // Ready depends only on flops, so there is no input-to-ready combinational path.
  assign data_cpu_to_noc_rdy = up_q && !ing_full;
  assign net_in_rdy          = up_q && !eg_full;

  assign tx_fire = data_cpu_to_noc_vld && data_cpu_to_noc_rdy;
  assign eg_push = net_in_vld && net_in_rdy;

  assign net_out_vld                 = !ing_empty;
  assign {net_out_src, net_out_data} = ing_head;
  assign ing_pop                     = net_out_vld && net_out_rdy;
  assign data_noc_to_cpu_vld         = !eg_empty;
  assign rx_fire                     = data_noc_to_cpu_vld && data_noc_to_cpu_rdy;

  noc_cpu_port_fifo #(.DEPTH(DEPTH), .W(96)) u_ingress (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_fire),
    .push_data ({cpu_index, data_cpu_to_noc}),
    .pop       (ing_pop),
    .full      (ing_full),
    .empty     (ing_empty),
    .head      (ing_head)
  );

  noc_cpu_port_fifo #(.DEPTH(DEPTH), .W(64)) u_egress (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (eg_push),
    .push_data (net_in_data),
    .pop       (rx_fire),
    .full      (eg_full),
    .empty     (eg_empty),
    .head      (data_noc_to_cpu)
  );

  // Done flags are sticky: a later counter wrap does not clear them.
  always_comb begin
    up_d       = 1'b1;
    tx_count_d = tx_count_q + {31'd0, tx_fire};
    rx_count_d = rx_count_q + {31'd0, rx_fire};
    tx_done_d  = tx_done_q || (tx_count_d == 32'(TRANSACTION_NB));
    rx_done_d  = rx_done_q || (rx_count_d == 32'(TRANSACTION_NB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q       <= 1'b0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      up_q       <= up_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
  assign tx_done  = tx_done_q;
  assign rx_done  = rx_done_q;

`ifdef NOC_CPU_PORT_CHECKSUM_EN
  logic [63:0] tx_checksum_q, tx_checksum_d, rx_checksum_q, rx_checksum_d;

  always_comb begin
    tx_checksum_d = tx_fire ? (tx_checksum_q ^ data_cpu_to_noc) : tx_checksum_q;
    rx_checksum_d = rx_fire ? (rx_checksum_q ^ data_noc_to_cpu) : rx_checksum_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_checksum_q <= '0;
      rx_checksum_q <= '0;
    end else begin
      tx_checksum_q <= tx_checksum_d;
      rx_checksum_q <= rx_checksum_d;
    end
  end

  assign tx_checksum = tx_checksum_q;
  assign rx_checksum = rx_checksum_q;
`endif
endmodule

// File: tb/tb_noc_cpu_port.sv
// Directed bench for noc_cpu_port (DEPTH=4, TRANSACTION_NB=8); inputs driven and outputs sampled on negedge.
`timescale 1ns/1ps

module tb_noc_cpu_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_index;
  logic        data_cpu_to_noc_vld;
  logic [63:0] data_cpu_to_noc;
  logic        data_cpu_to_noc_rdy;
  logic        data_noc_to_cpu_vld;
  logic [63:0] data_noc_to_cpu;
  logic        data_noc_to_cpu_rdy;
  logic        net_out_vld;
  logic [63:0] net_out_data;
  logic [31:0] net_out_src;
  logic        net_out_rdy;
  logic        net_in_vld;
  logic [63:0] net_in_data;
  logic        net_in_rdy;
  logic [31:0] tx_count, rx_count;
  logic        tx_done, rx_done;
`ifdef NOC_CPU_PORT_CHECKSUM_EN
  logic [63:0] tx_checksum, rx_checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_cpu_port #(.DEPTH(4), .TRANSACTION_NB(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cpu_index           (cpu_index),
    .data_cpu_to_noc_vld (data_cpu_to_noc_vld),
    .data_cpu_to_noc     (data_cpu_to_noc),
    .data_cpu_to_noc_rdy (data_cpu_to_noc_rdy),
    .data_noc_to_cpu_vld (data_noc_to_cpu_vld),
    .data_noc_to_cpu     (data_noc_to_cpu),
    .data_noc_to_cpu_rdy (data_noc_to_cpu_rdy),
    .net_out_vld         (net_out_vld),
    .net_out_data        (net_out_data),
    .net_out_src         (net_out_src),
    .net_out_rdy         (net_out_rdy),
    .net_in_vld          (net_in_vld),
    .net_in_data         (net_in_data),
    .net_in_rdy          (net_in_rdy),
    .tx_count            (tx_count),
    .rx_count            (rx_count),
    .tx_done             (tx_done),
    .rx_done             (rx_done)
`ifdef NOC_CPU_PORT_CHECKSUM_EN
    ,
    .tx_checksum         (tx_checksum),
    .rx_checksum         (rx_checksum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  logic [63:0] iw [5];
  logic [63:0] nw [6];

  initial begin
    int sent, got, occ;
    logic tog, push, pop;

    iw[0] = 64'h1111_0000_0000_0001; iw[1] = 64'h2222_0000_0000_0002;
    iw[2] = 64'h3333_0000_0000_0003; iw[3] = 64'h4444_0000_0000_0004;
    iw[4] = 64'h5555_0000_0000_0005;
    for (int i = 0; i < 6; i++) nw[i] = 64'hA000_0000_0000_0000 + 64'(i);

    rst_n = 1'b0; cpu_index = 32'd3;
    data_cpu_to_noc_vld = 1'b0; data_cpu_to_noc = '0; data_noc_to_cpu_rdy = 1'b0;
    net_out_rdy = 1'b0; net_in_vld = 1'b0; net_in_data = '0;

    // Reset state and release
    repeat (2) @(negedge clk);
    check("rst cpu_rdy", data_cpu_to_noc_rdy, 0);
    check("rst net_in_rdy", net_in_rdy, 0);
    check("rst net_out_vld", net_out_vld, 0);
    check("rst noc_to_cpu_vld", data_noc_to_cpu_vld, 0);
    check("rst net_out_data", net_out_data, 0);
    check("rst tx_count", tx_count, 0);
    check("rst rx_done", rx_done, 0);
    rst_n = 1'b1;
    #1;
    check("release cycle0 cpu_rdy", data_cpu_to_noc_rdy, 0);
    check("release cycle0 net_in_rdy", net_in_rdy, 0);
    @(negedge clk);
    check("release cycle1 cpu_rdy", data_cpu_to_noc_rdy, 1);
    check("release cycle1 net_in_rdy", net_in_rdy, 1);

    // Single word pass-through
    data_cpu_to_noc_vld = 1'b1; data_cpu_to_noc = 64'hdeadbeefdeadbeef; net_out_rdy = 1'b1;
    @(negedge clk);
    data_cpu_to_noc_vld = 1'b0;
    check("pass net_out_vld", net_out_vld, 1);
    check("pass net_out_data", net_out_data, 64'hdeadbeefdeadbeef);
    check("pass net_out_src", net_out_src, 3);
    check("pass tx_count", tx_count, 1);
    @(negedge clk);
    check("pass one cycle vld", net_out_vld, 0);

    // Ingress fill, offer a 5th word, then pop-at-full and drain
    net_out_rdy = 1'b0; cpu_index = 32'd5;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill rdy before word %0d", i), data_cpu_to_noc_rdy, 1);
      data_cpu_to_noc_vld = 1'b1; data_cpu_to_noc = iw[i];
      @(negedge clk);
    end
    data_cpu_to_noc = iw[4];
    check("full cpu_rdy", data_cpu_to_noc_rdy, 0);
    check("full head data", net_out_data, iw[0]);
    check("full head src", net_out_src, 5);
    check("full tx_count", tx_count, 5);
    @(negedge clk);
    check("full held cpu_rdy", data_cpu_to_noc_rdy, 0);
    check("full no overwrite tx_count", tx_count, 5);
    net_out_rdy = 1'b1;
    @(negedge clk);
    check("pop at full no push", tx_count, 5);
    check("pop at full head", net_out_data, iw[1]);
    check("rdy after first pop", data_cpu_to_noc_rdy, 1);
    @(negedge clk);
    data_cpu_to_noc_vld = 1'b0;
    check("push after pop tx_count", tx_count, 6);
    check("drain word2", net_out_data, iw[2]);
    @(negedge clk);
    check("drain word3", net_out_data, iw[3]);
    @(negedge clk);
    check("drain word4", net_out_data, iw[4]);
    @(negedge clk);
    check("drain empty vld", net_out_vld, 0);
    net_out_rdy = 1'b0;

    // Egress with CPU ready toggling 1,0,1,0...
    sent = 0; got = 0; occ = 0; tog = 1'b1;
    net_in_vld = 1'b1; net_in_data = nw[0]; data_noc_to_cpu_rdy = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      push = net_in_vld && net_in_rdy;
      pop  = data_noc_to_cpu_vld && data_noc_to_cpu_rdy;
      check($sformatf("egress net_in_rdy c%0d", cyc), net_in_rdy, occ < 4);
      check($sformatf("egress vld c%0d", cyc), data_noc_to_cpu_vld, occ != 0);
      if (pop) begin
        check($sformatf("egress word %0d", got), data_noc_to_cpu, nw[got]);
        got++;
      end
      if (push) sent++;
      occ = occ + int'(push) - int'(pop);
      @(negedge clk);
      net_in_vld  = (sent < 6);
      net_in_data = (sent < 6) ? nw[sent] : 64'd0;
      tog = !tog;
      data_noc_to_cpu_rdy = tog;
    end
    net_in_vld = 1'b0; data_noc_to_cpu_rdy = 1'b0;
    check("egress delivered count", 64'(got), 6);
    check("egress rx_count", rx_count, 6);
    check("egress empty after", data_noc_to_cpu_vld, 0);

    // Done flags with TRANSACTION_NB = 8, from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("done pre tx_count", tx_count, 0);
    check("done pre rx_count", rx_count, 0);
    net_out_rdy = 1'b1; data_noc_to_cpu_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_cpu_to_noc_vld = (k < 8); data_cpu_to_noc = 64'h100 + 64'(k);
      net_in_vld = (k < 8); net_in_data = 64'h200 + 64'(k);
      @(negedge clk);
      check($sformatf("done tx_count k%0d", k), tx_count, (k + 1 > 8) ? 8 : k + 1);
      check($sformatf("done tx_done k%0d", k), tx_done, k + 1 >= 8);
      check($sformatf("done rx_count k%0d", k), rx_count, (k > 8) ? 8 : k);
      check($sformatf("done rx_done k%0d", k), rx_done, k >= 8);
    end

    // Reset mid-stream with words buffered in both FIFOs
    net_out_rdy = 1'b0; data_noc_to_cpu_rdy = 1'b0;
    data_cpu_to_noc_vld = 1'b1; data_cpu_to_noc = 64'hCAFE;
    net_in_vld = 1'b1; net_in_data = 64'hBEEF;
    @(negedge clk);
    data_cpu_to_noc_vld = 1'b0; net_in_vld = 1'b0;
    check("midrst pre net_out_vld", net_out_vld, 1);
    check("midrst pre noc_to_cpu_vld", data_noc_to_cpu_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst async net_out_vld", net_out_vld, 0);
    check("midrst async noc_to_cpu_vld", data_noc_to_cpu_vld, 0);
    check("midrst async cpu_rdy", data_cpu_to_noc_rdy, 0);
    check("midrst async net_out_data", net_out_data, 0);
    check("midrst async tx_done", tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst net_out_vld", net_out_vld, 0);
    check("post rst noc_to_cpu_vld", data_noc_to_cpu_vld, 0);
    check("post rst tx_done", tx_done, 0);
    check("post rst rx_done", rx_done, 0);
    check("post rst rx_count", rx_count, 0);
    check("post rst net_in_rdy", net_in_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
